alarm_clock_ctrl: RTL and testbench
===================================

Name: alarm_clock_ctrl

Overview:
Central controller for the alarm clock. It derives 1 Hz timekeeping from the system clock and drives single-cycle minute/hour increment pulses into the minute/hour counter block, including the hour carry that the counter does not generate itself. It also sequences user modes (run, set time, set alarm), holds the alarm time, and runs the alarm/snooze state machine.

Parameters:
TICKS_PER_SEC, 100000000, clk cycles per second (benches use 4).
SNOOZE_MIN, 9, minutes spent in snooze before re-ringing.
RING_MIN, 10, minutes of ringing before auto-silence.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-high; clears all state.
btn_mode  input  1  one-cycle pulse, debounced upstream; advances mode.
btn_min  input  1  one-cycle pulse; minute increment in set modes.
btn_hour  input  1  one-cycle pulse; hour increment in set modes.
snooze  input  1  one-cycle pulse; snooze request.
alarm_en  input  1  level; alarm armed when high.
minutes_in  input  6  current minutes (0-59) from the counter block.
hours_in  input  6  current hours (0-23) from the counter block.
minute_out  output  1  registered one-cycle increment pulse to the counter's minute input.
hour_out  output  1  registered one-cycle increment pulse to the counter's hour input.
mode  output  2  0=RUN, 1=SET_TIME, 2=SET_ALARM.
alarm_min  output  6  alarm minutes.
alarm_hr  output  6  alarm hours.
alarm_ring  output  1  high while the alarm FSM is in RINGING.

Behaviour:
- Reset values: mode=0, minute_out=0, hour_out=0, alarm_min=0, alarm_hr=0, alarm_ring=0, prescaler=0, sec=0, alarm FSM=IDLE.
- Prescaler counts 0..TICKS_PER_SEC-1. sec advances on prescaler wrap and counts 0..59. Both run in RUN and SET_ALARM. Both are held at 0 in SET_TIME.
- Minute rollover: on the cycle where the prescaler wraps with sec==59, assert minute_out for 1 cycle. If minutes_in==59 in that same cycle, also assert hour_out in the same cycle.
- Mode FSM: each btn_mode pulse moves RUN->SET_TIME->SET_ALARM->RUN.
  - Entering SET_TIME clears the prescaler and sec.
  - btn_mode has priority: a btn_min, btn_hour or snooze arriving in the same cycle is ignored.
- SET_TIME:
  - btn_min gives one minute_out pulse, with no hour carry.
  - btn_hour gives one hour_out pulse.
  - Pulses appear 1 cycle after the button.
- SET_ALARM:
  - btn_min sets alarm_min to (alarm_min+1) mod 60.
  - btn_hour sets alarm_hr to (alarm_hr+1) mod 24.
  - Buttons pressed in the same cycle both apply.
- RUN: btn_min and btn_hour are ignored.
- match_strobe is registered and goes high the cycle after any rollover-generated minute_out. Button-generated pulses never raise it. It is used because minutes_in/hours_in are settled by then.
- Alarm FSM states: IDLE, RINGING, SNOOZED.
  - IDLE->RINGING: match_strobe && alarm_en && minutes_in==alarm_min && hours_in==alarm_hr. The ring-minute counter loads RING_MIN.
  - RINGING, snooze pulse: go to SNOOZED and load the snooze counter with SNOOZE_MIN.
  - RINGING, match_strobe: decrement the ring counter. When it reaches 0, go to IDLE.
  - SNOOZED, match_strobe: decrement the snooze counter. When it reaches 0, go to RINGING and reload the ring counter.
  - Any state, alarm_en low: go to IDLE, checked first.
  - Entering SET_TIME forces IDLE.
  - snooze outside RINGING is ignored.
  - snooze and match_strobe in the same cycle while RINGING: snooze wins.
- alarm_ring = (state==RINGING), registered.
- Reset asserted mid-pulse or mid-ring: outputs drop immediately (async clear). Timekeeping restarts at sec=0.

Test Plan:
- TICKS_PER_SEC=4, reset then RUN, minutes_in=12, hours_in=3 -> first minute_out at cycle 240 after reset release, width 1; hour_out stays 0.
- minutes_in=59, hours_in=7 at rollover -> minute_out and hour_out high in the same cycle, each for exactly 1 cycle.
- btn_mode once, then btn_min x3 and btn_hour x1 -> mode=1; 3 minute_out pulses and 1 hour_out pulse, each 1 cycle after its button; no rollover pulses for 1000 cycles.
- btn_mode twice, btn_hour x25, btn_min x61 -> mode=2, alarm_hr=1, alarm_min=1; btn_mode+btn_min in the same cycle -> mode=0, alarm_min unchanged.
- alarm 06:30, alarm_en=1, counter model at 06:29, rollover to 06:30 -> alarm_ring rises 2 cycles after minute_out; snooze -> alarm_ring=0; after 9 further rollovers -> alarm_ring=1; 10 rollovers later -> alarm_ring=0.
- While RINGING: drop alarm_en -> alarm_ring=0 next cycle. Assert reset mid-ring -> alarm_ring, mode, alarm_min and alarm_hr all 0 without waiting for clk.

Source files
------------

// File: rtl/alarm_clock_ctrl.sv
// Alarm clock central controller: 1 Hz timekeeping, minute/hour increment pulses,
// user mode sequencing, alarm time storage and the alarm/snooze state machine.
module alarm_clock_ctrl #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int SNOOZE_MIN    = 9,
  parameter int RING_MIN      = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_min,
  input  logic       btn_hour,
  input  logic       snooze,
  input  logic       alarm_en,
  input  logic [5:0] minutes_in,
  input  logic [5:0] hours_in,
  output logic       minute_out,
  output logic       hour_out,
  output logic [1:0] mode,
  output logic [5:0] alarm_min,
  output logic [5:0] alarm_hr,
  output logic       alarm_ring
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam int CNT_MAX = (RING_MIN > SNOOZE_MIN) ? RING_MIN : SNOOZE_MIN;
  localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [1:0] MODE_RUN       = 2'd0;
  localparam logic [1:0] MODE_SET_TIME  = 2'd1;
  localparam logic [1:0] MODE_SET_ALARM = 2'd2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RINGING = 2'd1;
  localparam logic [1:0] ST_SNOOZED = 2'd2;

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [5:0]    sec_q, sec_d;
  logic [1:0]    mode_q, mode_d;
  logic          minute_out_q, minute_out_d;
  logic          hour_out_q, hour_out_d;
  logic [5:0]    alarm_min_q, alarm_min_d;
  logic [5:0]    alarm_hr_q, alarm_hr_d;
  logic          roll_q;
  logic          match_strobe_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] ring_cnt_q, ring_cnt_d;
  logic [CW-1:0] snooze_cnt_q, snooze_cnt_d;
  logic          ring_q, ring_d;

  logic timing_run;
  logic enter_set_time;
  logic tick;
  logic rollover;
  logic set_time_btn;
  logic set_alarm_btn;
  logic snooze_act;
  logic alarm_hit;

  assign timing_run     = (mode_q != MODE_SET_TIME);
  assign enter_set_time = btn_mode && (mode_q == MODE_RUN);
  assign tick           = timing_run && (prescaler_q == PRESC_MAX);
  assign rollover       = tick && (sec_q == 6'd59);
  assign set_time_btn   = (mode_q == MODE_SET_TIME) && !btn_mode;
  assign set_alarm_btn  = (mode_q == MODE_SET_ALARM) && !btn_mode;
  assign snooze_act     = snooze && !btn_mode;
  // match_strobe lags the rollover pulse so the counter block has already settled
  assign alarm_hit      = match_strobe_q && (minutes_in == alarm_min_q) && (hours_in == alarm_hr_q);

  always_comb begin
    mode_d = mode_q;
    if (btn_mode) begin
      case (mode_q)
        MODE_RUN:      mode_d = MODE_SET_TIME;
        MODE_SET_TIME: mode_d = MODE_SET_ALARM;
        default:       mode_d = MODE_RUN;
      endcase
    end
  end

  always_comb begin
    prescaler_d = prescaler_q;
    sec_d       = sec_q;
    if (!timing_run || enter_set_time) begin
      prescaler_d = '0;
      sec_d       = '0;
    end else if (tick) begin
      prescaler_d = '0;
      sec_d       = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
    end else begin
      prescaler_d = prescaler_q + 1'b1;
    end
  end

  always_comb begin
    minute_out_d = rollover || (set_time_btn && btn_min);
    hour_out_d   = (rollover && (minutes_in == 6'd59)) || (set_time_btn && btn_hour);
  end

  always_comb begin
    alarm_min_d = alarm_min_q;
    alarm_hr_d  = alarm_hr_q;
    if (set_alarm_btn && btn_min) begin
      alarm_min_d = (alarm_min_q == 6'd59) ? 6'd0 : alarm_min_q + 6'd1;
    end
    if (set_alarm_btn && btn_hour) begin
      alarm_hr_d = (alarm_hr_q == 6'd23) ? 6'd0 : alarm_hr_q + 6'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    if (!alarm_en || enter_set_time) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (alarm_hit) begin
            state_d    = ST_RINGING;
            ring_cnt_d = CW'(RING_MIN);
          end
        end
        ST_RINGING: begin
          if (snooze_act) begin
            state_d      = ST_SNOOZED;
            snooze_cnt_d = CW'(SNOOZE_MIN);
          end else if (match_strobe_q) begin
            if (ring_cnt_q <= CW'(1)) begin
              state_d    = ST_IDLE;
              ring_cnt_d = '0;
            end else begin
              ring_cnt_d = ring_cnt_q - 1'b1;
            end
          end
        end
        ST_SNOOZED: begin
          if (match_strobe_q) begin
            if (snooze_cnt_q <= CW'(1)) begin
              state_d      = ST_RINGING;
              snooze_cnt_d = '0;
              ring_cnt_d   = CW'(RING_MIN);
            end else begin
              snooze_cnt_d = snooze_cnt_q - 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    ring_d = (state_d == ST_RINGING);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_q    <= '0;
      sec_q          <= '0;
      mode_q         <= MODE_RUN;
      minute_out_q   <= 1'b0;
      hour_out_q     <= 1'b0;
      alarm_min_q    <= '0;
      alarm_hr_q     <= '0;
      roll_q         <= 1'b0;
      match_strobe_q <= 1'b0;
      state_q        <= ST_IDLE;
      ring_cnt_q     <= '0;
      snooze_cnt_q   <= '0;
      ring_q         <= 1'b0;
    end else begin
      prescaler_q    <= prescaler_d;
      sec_q          <= sec_d;
      mode_q         <= mode_d;
      minute_out_q   <= minute_out_d;
      hour_out_q     <= hour_out_d;
      alarm_min_q    <= alarm_min_d;
      alarm_hr_q     <= alarm_hr_d;
      roll_q         <= rollover;
      match_strobe_q <= roll_q;
      state_q        <= state_d;
      ring_cnt_q     <= ring_cnt_d;
      snooze_cnt_q   <= snooze_cnt_d;
      ring_q         <= ring_d;
    end
  end

  assign minute_out = minute_out_q;
  assign hour_out   = hour_out_q;
  assign mode       = mode_q;
  assign alarm_min  = alarm_min_q;
  assign alarm_hr   = alarm_hr_q;
  assign alarm_ring = ring_q;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Bench for alarm_clock_ctrl: a bench-side minute/hour counter model feeds the DUT,
// expected pulses and alarm_ring edges are queued and matched as they appear.
module tb_alarm_clock_ctrl;

  localparam int TPS     = 4;
  localparam int MIN_CYC = TPS * 60;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_min = 1'b0;
  logic       btn_hour = 1'b0;
  logic       snooze = 1'b0;
  logic       alarm_en = 1'b0;
  logic [5:0] minutes_in = 6'd0;
  logic [5:0] hours_in = 6'd0;
  logic       minute_out;
  logic       hour_out;
  logic [1:0] mode;
  logic [5:0] alarm_min;
  logic [5:0] alarm_hr;
  logic       alarm_ring;

  typedef struct {int cyc; logic mn; logic hr;} pulse_t;
  typedef struct {int cyc; logic val;} ring_t;

  pulse_t pulse_q[$];
  ring_t  ring_q[$];
  int     cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  bit     model_en = 1'b0;
  int     e_cyc = 0;

  alarm_clock_ctrl #(
    .TICKS_PER_SEC(TPS),
    .SNOOZE_MIN(9),
    .RING_MIN(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_mode(btn_mode),
    .btn_min(btn_min),
    .btn_hour(btn_hour),
    .snooze(snooze),
    .alarm_en(alarm_en),
    .minutes_in(minutes_in),
    .hours_in(hours_in),
    .minute_out(minute_out),
    .hour_out(hour_out),
    .mode(mode),
    .alarm_min(alarm_min),
    .alarm_hr(alarm_hr),
    .alarm_ring(alarm_ring)
  );

  always #5 clk = ~clk;

  // One clock: buttons last exactly one edge; the counter model reacts to pulses.
  task automatic step();
    @(negedge clk);
    cyc++;
    btn_mode = 1'b0;
    btn_min  = 1'b0;
    btn_hour = 1'b0;
    snooze   = 1'b0;
    if (model_en) begin
      if (minute_out) minutes_in = (minutes_in == 6'd59) ? 6'd0 : minutes_in + 6'd1;
      if (hour_out)   hours_in   = (hours_in == 6'd23) ? 6'd0 : hours_in + 6'd1;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({mode, minute_out, hour_out, alarm_ring} !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: mode=%0d min_out=%b hr_out=%b ring=%b, required all 0",
               mode, minute_out, hour_out, alarm_ring);
    end
    n_checks++;
    if ({alarm_min, alarm_hr} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_alarm: alarm_min=%0d alarm_hr=%0d, required 0/0", alarm_min, alarm_hr);
    end
    repeat (2) @(negedge clk);
    release_reset();
    $display("reset: mode=%0d alarm=%0d:%0d ring=%b", mode, alarm_hr, alarm_min, alarm_ring);
  endtask

  task automatic test_rollover();
    pulse_t pe;
    model_en   = 1'b1;
    minutes_in = 6'd12;
    hours_in   = 6'd3;
    pulse_q.push_back('{MIN_CYC, 1'b1, 1'b0});
    while (cyc < MIN_CYC + 20) begin
      step();
      if (minute_out || hour_out) begin
        n_checks++;
        if (pulse_q.size() == 0) begin
          n_fail++;
          $display("FAIL rollover_extra: cyc=%0d min=%b hr=%b, required no pulse", cyc, minute_out, hour_out);
        end else begin
          pe = pulse_q.pop_front();
          if (cyc !== pe.cyc || minute_out !== pe.mn || hour_out !== pe.hr) begin
            n_fail++;
            $display("FAIL rollover_pulse: cyc=%0d min=%b hr=%b, required cyc=%0d min=%b hr=%b",
                     cyc, minute_out, hour_out, pe.cyc, pe.mn, pe.hr);
          end
        end
        $display("rollover: pulse at cyc %0d min=%b hr=%b", cyc, minute_out, hour_out);
      end
    end
    n_checks++;
    if (pulse_q.size() != 0) begin
      n_fail++;
      $display("FAIL rollover_missing: %0d pulses outstanding, required 0", pulse_q.size());
      pulse_q.delete();
    end
  endtask

  task automatic test_hour_carry();
    pulse_t pe;
    minutes_in = 6'd59;
    hours_in   = 6'd7;
    pulse_q.push_back('{2 * MIN_CYC, 1'b1, 1'b1});
    while (cyc < 2 * MIN_CYC + 10) begin
      step();
      if (minute_out || hour_out) begin
        n_checks++;
        if (pulse_q.size() == 0) begin
          n_fail++;
          $display("FAIL carry_extra: cyc=%0d min=%b hr=%b, required no pulse", cyc, minute_out, hour_out);
        end else begin
          pe = pulse_q.pop_front();
          if (cyc !== pe.cyc || minute_out !== pe.mn || hour_out !== pe.hr) begin
            n_fail++;
            $display("FAIL carry_pulse: cyc=%0d min=%b hr=%b, required cyc=%0d min=%b hr=%b",
                     cyc, minute_out, hour_out, pe.cyc, pe.mn, pe.hr);
          end
        end
        $display("carry: pulse at cyc %0d min=%b hr=%b", cyc, minute_out, hour_out);
      end
    end
    n_checks++;
    if (pulse_q.size() != 0) begin
      n_fail++;
      $display("FAIL carry_missing: %0d pulses outstanding, required 0", pulse_q.size());
      pulse_q.delete();
    end
  endtask

  task automatic test_set_time();
    pulse_t pe;
    btn_mode = 1'b1;
    step();
    n_checks++;
    if (mode !== 2'd1) begin
      n_fail++;
      $display("FAIL set_time_mode: mode=%0d, required 1", mode);
    end
    for (int i = 0; i < 1100; i++) begin
      if (i == 5 || i == 15 || i == 25) begin
        btn_min = 1'b1;
        pulse_q.push_back('{cyc + 1, 1'b1, 1'b0});
      end
      if (i == 35) begin
        btn_hour = 1'b1;
        pulse_q.push_back('{cyc + 1, 1'b0, 1'b1});
      end
      step();
      if (minute_out || hour_out) begin
        n_checks++;
        if (pulse_q.size() == 0) begin
          n_fail++;
          $display("FAIL set_time_extra: cyc=%0d min=%b hr=%b, required no pulse", cyc, minute_out, hour_out);
        end else begin
          pe = pulse_q.pop_front();
          if (cyc !== pe.cyc || minute_out !== pe.mn || hour_out !== pe.hr) begin
            n_fail++;
            $display("FAIL set_time_pulse: cyc=%0d min=%b hr=%b, required cyc=%0d min=%b hr=%b",
                     cyc, minute_out, hour_out, pe.cyc, pe.mn, pe.hr);
          end
        end
        $display("set_time: pulse at cyc %0d min=%b hr=%b", cyc, minute_out, hour_out);
      end
    end
    n_checks++;
    if (pulse_q.size() != 0) begin
      n_fail++;
      $display("FAIL set_time_missing: %0d pulses outstanding, required 0", pulse_q.size());
      pulse_q.delete();
    end
  endtask

  task automatic test_set_alarm();
    int exp_min = 0;
    int exp_hr = 0;
    int pulses = 0;
    btn_mode = 1'b1;
    step();
    n_checks++;
    if (mode !== 2'd2) begin
      n_fail++;
      $display("FAIL set_alarm_mode: mode=%0d, required 2", mode);
    end
    for (int i = 0; i < 86; i++) begin
      if (i < 25) begin
        btn_hour = 1'b1;
        exp_hr = (exp_hr + 1) % 24;
      end else begin
        btn_min = 1'b1;
        exp_min = (exp_min + 1) % 60;
      end
      step();
      if (minute_out || hour_out) pulses++;
    end
    n_checks++;
    if (alarm_hr !== 6'(exp_hr) || alarm_min !== 6'(exp_min) || pulses != 0) begin
      n_fail++;
      $display("FAIL set_alarm_wrap: alarm=%0d:%0d pulses=%0d, required %0d:%0d pulses=0",
               alarm_hr, alarm_min, pulses, exp_hr, exp_min);
    end
    btn_min  = 1'b1;
    btn_hour = 1'b1;
    exp_min  = (exp_min + 1) % 60;
    exp_hr   = (exp_hr + 1) % 24;
    step();
    n_checks++;
    if (alarm_hr !== 6'(exp_hr) || alarm_min !== 6'(exp_min)) begin
      n_fail++;
      $display("FAIL set_alarm_both: alarm=%0d:%0d, required %0d:%0d", alarm_hr, alarm_min, exp_hr, exp_min);
    end
    btn_mode = 1'b1;
    btn_min  = 1'b1;
    step();
    n_checks++;
    if (mode !== 2'd0 || alarm_min !== 6'(exp_min)) begin
      n_fail++;
      $display("FAIL mode_priority: mode=%0d alarm_min=%0d, required 0 and %0d", mode, alarm_min, exp_min);
    end
    $display("set_alarm: alarm=%0d:%0d mode=%0d", alarm_hr, alarm_min, mode);
  endtask

  task automatic test_alarm_snooze();
    ring_t re;
    logic  ring_prev;
    int    s_cyc;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    release_reset();
    alarm_en   = 1'b1;
    minutes_in = 6'd29;
    hours_in   = 6'd6;
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b1;
    step();
    e_cyc = cyc;
    for (int i = 0; i < 6; i++) begin
      btn_hour = 1'b1;
      step();
    end
    for (int i = 0; i < 30; i++) begin
      btn_min = 1'b1;
      step();
    end
    btn_mode = 1'b1;
    step();
    n_checks++;
    if (mode !== 2'd0 || alarm_hr !== 6'd6 || alarm_min !== 6'd30) begin
      n_fail++;
      $display("FAIL alarm_setup: mode=%0d alarm=%0d:%0d, required 0 and 6:30", mode, alarm_hr, alarm_min);
    end
    s_cyc = e_cyc + MIN_CYC + 10;
    ring_q.push_back('{e_cyc + MIN_CYC + 2, 1'b1});
    ring_q.push_back('{s_cyc + 1, 1'b0});
    ring_q.push_back('{e_cyc + 10 * MIN_CYC + 2, 1'b1});
    ring_q.push_back('{e_cyc + 20 * MIN_CYC + 2, 1'b0});
    ring_prev = alarm_ring;
    while (cyc < e_cyc + 20 * MIN_CYC + 30) begin
      if (cyc == s_cyc) snooze = 1'b1;
      step();
      if (alarm_ring !== ring_prev) begin
        n_checks++;
        if (ring_q.size() == 0) begin
          n_fail++;
          $display("FAIL ring_extra: cyc=%0d ring=%b, required no change", cyc, alarm_ring);
        end else begin
          re = ring_q.pop_front();
          if (cyc !== re.cyc || alarm_ring !== re.val) begin
            n_fail++;
            $display("FAIL ring_edge: cyc=%0d ring=%b, required cyc=%0d ring=%b", cyc, alarm_ring, re.cyc, re.val);
          end
        end
        $display("alarm: ring=%b at cyc %0d time %0d:%0d", alarm_ring, cyc, hours_in, minutes_in);
        ring_prev = alarm_ring;
      end
    end
    n_checks++;
    if (ring_q.size() != 0) begin
      n_fail++;
      $display("FAIL ring_missing: %0d edges outstanding, required 0", ring_q.size());
      ring_q.delete();
    end
  endtask

  task automatic test_alarm_en_drop();
    int p_cyc;
    minutes_in = 6'd29;
    p_cyc = e_cyc + 21 * MIN_CYC;
    for (int i = 0; i < 400 && alarm_ring !== 1'b1; i++) step();
    n_checks++;
    if (alarm_ring !== 1'b1 || cyc !== p_cyc + 2) begin
      n_fail++;
      $display("FAIL en_ring_rise: ring=%b cyc=%0d, required 1 at cyc %0d", alarm_ring, cyc, p_cyc + 2);
    end
    alarm_en = 1'b0;
    step();
    n_checks++;
    if (alarm_ring !== 1'b0) begin
      n_fail++;
      $display("FAIL en_drop: ring=%b, required 0", alarm_ring);
    end
    alarm_en = 1'b1;
    $display("en_drop: ring=%b at cyc %0d", alarm_ring, cyc);
  endtask

  task automatic test_reset_mid_ring();
    pulse_t pe;
    minutes_in = 6'd29;
    for (int i = 0; i < 400 && alarm_ring !== 1'b1; i++) step();
    n_checks++;
    if (alarm_ring !== 1'b1) begin
      n_fail++;
      $display("FAIL midring_setup: ring=%b, required 1", alarm_ring);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({alarm_ring, mode, alarm_min, alarm_hr, minute_out, hour_out} !== 17'd0) begin
      n_fail++;
      $display("FAIL async_reset: ring=%b mode=%0d alarm=%0d:%0d, required all 0",
               alarm_ring, mode, alarm_hr, alarm_min);
    end
    @(negedge clk);
    release_reset();
    minutes_in = 6'd12;
    hours_in   = 6'd3;
    pulse_q.push_back('{MIN_CYC, 1'b1, 1'b0});
    while (cyc < MIN_CYC + 5) begin
      step();
      if (minute_out || hour_out) begin
        n_checks++;
        if (pulse_q.size() == 0) begin
          n_fail++;
          $display("FAIL restart_extra: cyc=%0d, required no pulse", cyc);
        end else begin
          pe = pulse_q.pop_front();
          if (cyc !== pe.cyc || minute_out !== pe.mn || hour_out !== pe.hr) begin
            n_fail++;
            $display("FAIL restart_pulse: cyc=%0d min=%b hr=%b, required cyc=%0d min=%b hr=%b",
                     cyc, minute_out, hour_out, pe.cyc, pe.mn, pe.hr);
          end
        end
        $display("restart: pulse at cyc %0d", cyc);
      end
    end
    n_checks++;
    if (pulse_q.size() != 0) begin
      n_fail++;
      $display("FAIL restart_missing: %0d pulses outstanding, required 0", pulse_q.size());
      pulse_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_hour_carry();
    test_set_time();
    test_set_alarm();
    test_alarm_snooze();
    test_alarm_en_drop();
    test_reset_mid_ring();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
